// File: rtl/mips_boot_pkg.sv
// Shared types for the byte-serial MIPS program loader.
// State encoding and the width of the frame's word-count field.
package mips_boot_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } boot_state_t;

endpackage

// File: rtl/boot_word_packer.sv
// Collects four stream bytes into one big-endian word (first byte lands in [31:24]).
// The completed word is held until the next one finishes; word_valid pulses once per word.
module boot_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_data,
  input  logic        byte_en,
  output logic [1:0]  byte_cnt,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift      <= '0;
      byte_cnt   <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_en) begin
        byte_cnt <= byte_cnt + 2'd1;
        shift    <= {shift[15:0], byte_data};
        if (byte_cnt == 2'd3) begin
          word       <= {shift, byte_data};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mips_boot_loader.sv
// Framed byte-stream loader for the MIPS instruction memory; holds the core in
// reset until a complete image with a matching XOR checksum has been written.
//
// state  | meaning
// LEN_HI | waiting for the high byte of the word count
// LEN_LO | waiting for the low byte; count is range-checked here
// DATA   | packing data bytes into words and writing them out
// CSUM   | comparing the final byte against the running XOR
// DONE   | image good, core released (absorbing)
// ERR    | oversize count or bad checksum (absorbing)
module mips_boot_loader
  import mips_boot_pkg::*;
#(
  parameter int unsigned       MAX_WORDS = 1024,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  boot_state_t      state, state_nxt;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] index;
  logic [7:0]       csum;
  logic [LEN_W-1:0] len_new;
  logic [1:0]       byte_cnt;
  logic             accept;
  logic             word_end;
  logic             last_word;

  assign accept    = in_valid & in_ready;
  assign len_new   = {len[LEN_W-1:8], in_data};
  assign word_end  = accept && (state == DATA) && (byte_cnt == 2'd3);
  assign last_word = (index == len - LEN_W'(1));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      LEN_HI: begin
        in_ready = 1'b1;
        if (accept) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        in_ready = 1'b1;
        if (accept) begin
          if (32'(len_new) > MAX_WORDS) state_nxt = ERR;
          else if (len_new == '0)       state_nxt = CSUM;
          else                          state_nxt = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (word_end && last_word) state_nxt = CSUM;
      end
      CSUM: begin
        in_ready = 1'b1;
        if (accept) state_nxt = (in_data == csum) ? DONE : ERR;
      end
      DONE:    state_nxt = DONE;
      ERR:     state_nxt = ERR;
      default: state_nxt = ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LEN_HI;
      len       <= '0;
      index     <= '0;
      csum      <= '0;
      imem_addr <= BASE_ADDR;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cpu_rst <= (state_nxt != DONE);
      done    <= (state_nxt == DONE);
      error   <= (state_nxt == ERR);
      if (accept && state != CSUM) csum <= csum ^ in_data;
      if (accept && state == LEN_HI) len[LEN_W-1:8] <= in_data;
      if (accept && state == LEN_LO) len[7:0] <= in_data;
      // address is latched alongside the packer's word so both appear together
      if (word_end) begin
        imem_addr <= BASE_ADDR + ADDR_W'({index, 2'b00});
        index     <= index + LEN_W'(1);
      end
    end
  end

  boot_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_data  (in_data),
    .byte_en    (accept && (state == DATA)),
    .byte_cnt   (byte_cnt),
    .word       (imem_wdata),
    .word_valid (imem_we)
  );

endmodule

// File: doc/mips_boot_loader.md
# mips_boot_loader

Byte-serial program loader sitting directly upstream of the single-cycle MIPS core. It receives a framed program image over a valid/ready byte stream, assembles big-endian 32-bit words, and writes them into the instruction memory's write port. Frame integrity is checked with an XOR checksum. The core is held in reset until a good image has been written.

## Interface

**Parameters**
- `MAX_WORDS`, default 1024: largest accepted word count. A larger count is an error.
- `ADDR_W`, default 32: width of the instruction-memory byte address.
- `BASE_ADDR`, default 0: byte address of the first written word.

**Ports**
- `clk`  input  1: single clock, rising-edge.
- `rst`  input  1: synchronous, active-high reset.
- `in_data`  input  8: stream byte.
- `in_valid`  input  1: `in_data` is valid.
- `in_ready`  output  1: loader accepts a byte. A byte transfers on `in_valid & in_ready`.
- `imem_we`  output  1: one-cycle instruction-memory write strobe.
- `imem_addr`  output  ADDR_W: byte address, `BASE_ADDR + 4*index`.
- `imem_wdata`  output  32: assembled instruction word.
- `cpu_rst`  output  1: reset to the MIPS core, active-high.
- `done`  output  1: image loaded and checksum matched.
- `error`  output  1: oversize length or checksum mismatch.

## Operation

**Frame format**
- LEN_HI byte, then LEN_LO byte: 16-bit word count N.
- 4·N data bytes. Each word is big-endian: the first byte is bits [31:24].
- One CSUM byte, equal to the XOR of every preceding frame byte, length bytes included.

**States** (transitions happen only on an accepted byte, except where noted)
- LEN_HI → LEN_LO.
- LEN_LO:
  - N > MAX_WORDS → ERR.
  - N == 0 → CSUM.
  - otherwise → DATA.
- DATA: a 2-bit byte counter shifts bytes into the word.
  - On the 4th byte, issue the write and increment the word index.
  - After word N−1 is complete → CSUM.
- CSUM: accepted byte equals the running XOR → DONE, otherwise → ERR.
- DONE and ERR are absorbing; only `rst` leaves them.

**Outputs per state**
- `in_ready` is combinational from state: 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 in DONE and ERR.
- `cpu_rst` is 1 in every state except DONE.
- `done` is 1 only in DONE; `error` is 1 only in ERR.

**Widths**
- The word index is 16 bits.
- `imem_addr` = `BASE_ADDR + {index, 2'b00}`, truncated to ADDR_W.
- The running XOR is 8 bits.

**Upstream behaviour**
- Bytes offered while `in_ready` = 0 are ignored and never counted.
- Gaps in `in_valid` may be of any length and do not disturb state.

## Timing

**Reset values** (all outputs registered except `in_ready`)
- State LEN_HI, so `in_ready` = 1 in the cycle after reset.
- `imem_we` = 0, `imem_addr` = `BASE_ADDR`, `imem_wdata` = 0.
- `cpu_rst` = 1, `done` = 0, `error` = 0.
- Word index, byte counter and XOR are all 0.

**Latencies**
- Write: `imem_we`, `imem_addr` and `imem_wdata` are valid for exactly one cycle, the cycle after the handshake of a word's 4th byte. They hold their values afterwards, with `imem_we` = 0.
- Back-to-back words: one byte per cycle produces at most one write every 4 cycles.
- Release: `cpu_rst` falls and `done` rises in the cycle after the matching CSUM handshake. The last write always precedes this by at least one cycle.
- Errors: `error` rises in the cycle after the offending LEN_LO or CSUM handshake.

**Reset mid-frame**
- Return to LEN_HI and discard the partial word and the XOR.
- `cpu_rst` returns to 1 immediately on the registered edge.
- Words already written to instruction memory are not erased.

**Other boundaries**
- N == MAX_WORDS is accepted.
- N == 0 expects CSUM = XOR of the two length bytes.

## Structure

**Package `mips_boot_pkg`**
- State enum: LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
- `LEN_W` = 16.

**Sub-module `boot_word_packer`**
- 4-byte shift register with a byte counter.
- Outputs the completed word and a one-cycle `word_valid`.
- Cleared by `rst`.

**Top-level MIPS wrapper**
- Drives the core's `rst` from `cpu_rst`.
- ORs the loader's write port into the instruction memory.

## Test plan

- **Nominal image:** bytes 00 02 20 08 00 05 20 09 00 0A 0C.
  - Writes 0x20080005 @0x0 and 0x2009000A @0x4, one `imem_we` pulse each.
  - `cpu_rst` falls and `done` = 1 one cycle after the 0x0C handshake.
- **Bad checksum:** same frame ending in 0x0D.
  - Both writes still occur.
  - `error` = 1, `cpu_rst` stays 1, `in_ready` = 0.
- **Oversize length:** 0x04 0x01 with MAX_WORDS = 1024.
  - ERR one cycle after LEN_LO, no `imem_we`.
  - Further bytes are ignored.
- **Zero length:** 00 00 00 → DONE, no writes.
- **Stalled source:** nominal frame with `in_valid` deasserted for 3 cycles between every byte.
  - Identical writes and addresses to the nominal case.
  - `imem_we` is never high for more than 1 cycle.
- **Reset mid-frame:** `rst` pulsed after byte 5 of the nominal frame, then the full nominal frame is resent.
  - State returns to LEN_HI and `cpu_rst` = 1.
  - The resent frame loads correctly to 0x0 and 0x4, and `done` = 1.
